// File: rtl/uart_frame_counter_if.sv
// Handshake and status bundle between a UART transmit shifter and its frame counter.
interface uart_frame_counter_if;
  logic       baud_tick;
  logic       shift_en;
  logic [2:0] phase;
  logic [3:0] bit_idx;
  logic [3:0] bit_pos;
  logic       busy;
  logic       done;
  logic       abort;

  modport master (
    output baud_tick, shift_en,
    input  phase, bit_idx, bit_pos, busy, done, abort
  );

  modport slave (
    input  baud_tick, shift_en,
    output phase, bit_idx, bit_pos, busy, done, abort
  );
endinterface

// File: rtl/uart_frame_counter.sv
// Parametrised UART frame sequencer: start, data, optional parity, stop bits, one per baud_tick.
// Parity phase is compiled in when UART_FRAME_PARITY_EN is defined.
module uart_frame_counter #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst_n,
  uart_frame_counter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state_reg, state_next;
  logic [3:0] bit_idx_reg, bit_idx_next;
  logic [3:0] bit_pos_reg, bit_pos_next;
  logic       stop_cnt_reg, stop_cnt_next;
  logic       prev_shift_en_reg;
  logic       done_reg, done_next;
  logic       abort_reg, abort_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      bit_idx_reg       <= 4'd0;
      bit_pos_reg       <= 4'd0;
      stop_cnt_reg      <= 1'b0;
      prev_shift_en_reg <= 1'b0;
      done_reg          <= 1'b0;
      abort_reg         <= 1'b0;
    end else begin
      state_reg         <= state_next;
      bit_idx_reg       <= bit_idx_next;
      bit_pos_reg       <= bit_pos_next;
      stop_cnt_reg      <= stop_cnt_next;
      prev_shift_en_reg <= bus.shift_en;
      done_reg          <= done_next;
      abort_reg         <= abort_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_idx_next  = bit_idx_reg;
    bit_pos_next  = bit_pos_reg;
    stop_cnt_next = stop_cnt_reg;
    done_next     = 1'b0;
    abort_next    = 1'b0;

    if (state_reg == IDLE) begin
      // A start edge coincident with baud_tick does not consume that tick.
      if (bus.shift_en && !prev_shift_en_reg) begin
        state_next    = START;
        bit_idx_next  = 4'd0;
        bit_pos_next  = 4'd0;
        stop_cnt_next = 1'b0;
      end
    end else if (!bus.shift_en) begin
      // Abort wins over a simultaneous tick.
      state_next    = IDLE;
      bit_idx_next  = 4'd0;
      bit_pos_next  = 4'd0;
      stop_cnt_next = 1'b0;
      abort_next    = 1'b1;
    end else if (bus.baud_tick) begin
      bit_pos_next = bit_pos_reg + 4'd1;
      case (state_reg)
        START: begin
          state_next   = DATA;
          bit_idx_next = 4'd0;
        end
        DATA: begin
          if (bit_idx_reg == LAST_IDX) begin
            bit_idx_next  = 4'd0;
            stop_cnt_next = 1'b0;
`ifdef UART_FRAME_PARITY_EN
            state_next    = PARITY;
`else
            state_next    = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
`ifdef UART_FRAME_PARITY_EN
        PARITY: begin
          state_next    = STOP;
          stop_cnt_next = 1'b0;
        end
`endif
        STOP: begin
          if (stop_cnt_reg == LAST_STOP) begin
            state_next    = IDLE;
            bit_pos_next  = 4'd0;
            stop_cnt_next = 1'b0;
            done_next     = 1'b1;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          bit_idx_next = 4'd0;
          bit_pos_next = 4'd0;
        end
      endcase
    end
  end

  assign bus.phase   = state_reg;
  assign bus.bit_idx = bit_idx_reg;
  assign bus.bit_pos = bit_pos_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = done_reg;
  assign bus.abort   = abort_reg;

endmodule

// File: tb/tb_uart_frame_counter.sv
// Directed bench for uart_frame_counter: default instance plus a 7-data/2-stop instance.
module tb_uart_frame_counter;

`ifdef UART_FRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL0 = 1 + 8 + P + 1;
  localparam int FL1 = 1 + 7 + P + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bt = 1'b0;
  logic se0 = 1'b0;
  logic se1 = 1'b0;

  int check_cnt = 0;
  int pass_cnt = 0;
  int done0 = 0;
  int done1 = 0;
  int abort0 = 0;
  int abort1 = 0;

  always #5 clk = ~clk;

  uart_frame_counter_if bus0 ();
  uart_frame_counter_if bus1 ();

  assign bus0.baud_tick = bt;
  assign bus0.shift_en  = se0;
  assign bus1.baud_tick = bt;
  assign bus1.shift_en  = se1;

  uart_frame_counter dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  uart_frame_counter #(.DATA_BITS(7), .STOP_BITS(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always @(negedge clk) begin
    if (bus0.done)  done0++;
    if (bus1.done)  done1++;
    if (bus0.abort) abort0++;
    if (bus1.abort) abort1++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    check_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int o_phase(input int d);
    return (d == 0) ? int'(bus0.phase) : int'(bus1.phase);
  endfunction
  function automatic int o_idx(input int d);
    return (d == 0) ? int'(bus0.bit_idx) : int'(bus1.bit_idx);
  endfunction
  function automatic int o_pos(input int d);
    return (d == 0) ? int'(bus0.bit_pos) : int'(bus1.bit_pos);
  endfunction
  function automatic int o_busy(input int d);
    return (d == 0) ? int'(bus0.busy) : int'(bus1.busy);
  endfunction
  function automatic int o_done(input int d);
    return (d == 0) ? int'(bus0.done) : int'(bus1.done);
  endfunction
  function automatic int o_abort(input int d);
    return (d == 0) ? int'(bus0.abort) : int'(bus1.abort);
  endfunction

  // Expected phase after k consumed ticks of a frame.
  function automatic int exp_phase(input int k, input int dbits, input int sbits);
    if (k == 0) return 1;
    if (k <= dbits) return 2;
    if (k <= dbits + P) return 3;
    if (k < 1 + dbits + P + sbits) return 4;
    return 0;
  endfunction

  task automatic set_se(input int d, input logic v);
    if (d == 0) se0 = v;
    else se1 = v;
  endtask

  task automatic start(input int d, input string tag);
    @(negedge clk);
    set_se(d, 1'b1);
    @(negedge clk);
    chk({tag, "_start_phase"}, o_phase(d), 1);
    chk({tag, "_start_pos"}, o_pos(d), 0);
    chk({tag, "_start_busy"}, o_busy(d), 1);
    $display("%s: frame started on dut%0d", tag, d);
  endtask

  task automatic run_ticks(input int d, input int first, input int last,
                           input int dbits, input int sbits, input int gap,
                           input string tag);
    int fl;
    int ph;
    fl = 1 + dbits + P + sbits;
    for (int k = first; k <= last; k++) begin
      repeat (gap) @(negedge clk);
      bt = 1'b1;
      @(negedge clk);
      bt = 1'b0;
      ph = exp_phase(k, dbits, sbits);
      chk($sformatf("%s_k%0d_phase", tag, k), o_phase(d), ph);
      chk($sformatf("%s_k%0d_idx", tag, k), o_idx(d), (ph == 2) ? k - 1 : 0);
      chk($sformatf("%s_k%0d_pos", tag, k), o_pos(d), (k >= fl) ? 0 : k);
      chk($sformatf("%s_k%0d_busy", tag, k), o_busy(d), (ph != 0) ? 1 : 0);
      chk($sformatf("%s_k%0d_done", tag, k), o_done(d), (k == fl) ? 1 : 0);
      $display("%s: tick %0d phase=%0d idx=%0d pos=%0d done=%0d",
               tag, k, o_phase(d), o_idx(d), o_pos(d), o_done(d));
    end
    if (last == fl) begin
      @(negedge clk);
      chk({tag, "_done_drop"}, o_done(d), 0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_phase", o_phase(0), 0);
    chk("rst_idx", o_idx(0), 0);
    chk("rst_pos", o_pos(0), 0);
    chk("rst_busy", o_busy(0), 0);
    chk("rst_done", o_done(0), 0);
    chk("rst_abort", o_abort(0), 0);
    chk("rst1_phase", o_phase(1), 0);
    $display("reset: outputs checked");
    rst_n = 1'b1;

    // Ticks in IDLE are ignored
    repeat (3) @(negedge clk);
    bt = 1'b1;
    @(negedge clk);
    bt = 1'b0;
    chk("idle_tick_phase", o_phase(0), 0);
    $display("idle tick: phase=%0d", o_phase(0));

    // Full default frame, 16-cycle tick spacing
    start(0, "f1");
    run_ticks(0, 1, FL0, 8, 1, 15, "f1");
    chk("f1_done_cnt", done0, 1);

    // shift_en held high: no new frame
    for (int i = 0; i < 20; i++) begin
      repeat (2) @(negedge clk);
      bt = 1'b1;
      @(negedge clk);
      bt = 1'b0;
      chk($sformatf("hold_%0d_phase", i), o_phase(0), 0);
    end
    chk("hold_done_cnt", done0, 1);
    $display("hold: 20 ticks, phase=%0d done_cnt=%0d", o_phase(0), done0);

    // Toggle to restart, then abort after tick 4 with a coincident tick
    se0 = 1'b0;
    start(0, "ab");
    run_ticks(0, 1, 4, 8, 1, 3, "ab");
    se0 = 1'b0;
    bt  = 1'b1;
    @(negedge clk);
    bt = 1'b0;
    chk("ab_abort", o_abort(0), 1);
    chk("ab_phase", o_phase(0), 0);
    chk("ab_pos", o_pos(0), 0);
    chk("ab_idx", o_idx(0), 0);
    chk("ab_busy", o_busy(0), 0);
    chk("ab_done", o_done(0), 0);
    @(negedge clk);
    chk("ab_abort_drop", o_abort(0), 0);
    chk("ab_abort_cnt", abort0, 1);
    chk("ab_done_cnt", done0, 1);
    $display("abort: pulse seen, abort_cnt=%0d", abort0);

    // Normal frame after abort
    start(0, "f2");
    run_ticks(0, 1, FL0, 8, 1, 4, "f2");
    chk("f2_done_cnt", done0, 2);

    // Start edge coincident with a tick: tick not consumed
    se0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    se0 = 1'b1;
    bt  = 1'b1;
    @(negedge clk);
    bt = 1'b0;
    chk("co_phase", o_phase(0), 1);
    chk("co_pos", o_pos(0), 0);
    $display("coincident: phase=%0d pos=%0d", o_phase(0), o_pos(0));
    run_ticks(0, 1, FL0, 8, 1, 3, "co");
    chk("co_done_cnt", done0, 3);

    // Reset during DATA at bit_idx 5
    se0 = 1'b0;
    start(0, "rs");
    run_ticks(0, 1, 6, 8, 1, 3, "rs");
    #2;
    rst_n = 1'b0;
    se0   = 1'b0;
    #1;
    chk("rs_phase", o_phase(0), 0);
    chk("rs_idx", o_idx(0), 0);
    chk("rs_pos", o_pos(0), 0);
    chk("rs_busy", o_busy(0), 0);
    chk("rs_done", o_done(0), 0);
    chk("rs_abort", o_abort(0), 0);
    $display("mid-frame reset: phase=%0d idx=%0d", o_phase(0), o_idx(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start(0, "f3");
    run_ticks(0, 1, FL0, 8, 1, 3, "f3");
    chk("f3_done_cnt", done0, 4);
    chk("f3_abort_cnt", abort0, 1);

    // 7 data bits, 2 stop bits instance
    start(1, "g1");
    run_ticks(1, 1, FL1, 7, 2, 3, "g1");
    chk("g1_done_cnt", done1, 1);
    chk("g1_abort_cnt", abort1, 0);
    chk("g1_dut0_done_cnt", done0, 4);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
